// File: rtl/prbs_lfsr_gen.sv
// Fibonacci LFSR pseudo-random generator with valid/ready output, seed load,
// zero-seed rejection and period measurement against a captured reference state.
module prbs_lfsr_gen #(
  parameter int             N     = 4,
  parameter logic [N-1:0]   TAPS  = 4'b1001,
  parameter logic [N-1:0]   SEED  = {N{1'b1}},
  parameter int             OUT_W = 1
) (
  input  logic             clk,
  input  logic             res,
  input  logic             en,
  input  logic             load,
  input  logic [N-1:0]     seed,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic [N-1:0]     state,
  output logic             wrap,
  output logic [N-1:0]     period,
  output logic             lockup_err
);

  logic [N-1:0] d_q, d_d;
  logic [N-1:0] ref_q, ref_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic [N-1:0] period_q, period_d;
  logic         wrap_q, wrap_d;
  logic         lockup_q, lockup_d;
  logic [N-1:0] d_adv;
  logic         xfer;

  function automatic logic [N-1:0] lfsr_step(input logic [N-1:0] d);
    return {^(d & TAPS), d[N-1:1]};
  endfunction

  assign out_valid  = en & ~load & res;
  assign xfer       = out_valid & out_ready;
  assign out_data   = d_q[OUT_W-1:0];
  assign state      = d_q;
  assign wrap       = wrap_q;
  assign period     = period_q;
  assign lockup_err = lockup_q;

  // One transfer consumes OUT_W serial bits, so the register jumps OUT_W steps at once.
  always_comb begin
    d_adv = d_q;
    for (int i = 0; i < OUT_W; i++) begin
      d_adv = lfsr_step(d_adv);
    end
  end

  always_comb begin
    d_d      = d_q;
    ref_d    = ref_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    wrap_d   = 1'b0;
    lockup_d = 1'b0;
    if (load) begin
      // A zero seed would freeze the register forever, so fall back to SEED instead.
      if (seed == '0) begin
        d_d      = SEED;
        ref_d    = SEED;
        lockup_d = 1'b1;
      end else begin
        d_d   = seed;
        ref_d = seed;
      end
      cnt_d = '0;
    end else if (xfer) begin
      d_d = d_adv;
      if (d_adv == ref_q) begin
        wrap_d   = 1'b1;
        period_d = cnt_q + N'(1);
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + N'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      d_q      <= SEED;
      ref_q    <= SEED;
      cnt_q    <= '0;
      period_q <= '0;
      wrap_q   <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      d_q      <= d_d;
      ref_q    <= ref_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      wrap_q   <= wrap_d;
      lockup_q <= lockup_d;
    end
  end

endmodule

// File: tb/tb_prbs_lfsr_gen.sv
// Scoreboard bench for prbs_lfsr_gen: default serial, 4-bit-wide and 7-bit instances
// share the control inputs; each test only checks the instance it exercises.
module tb_prbs_lfsr_gen;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic       out_ready = 1'b0;
  logic [3:0] seed4 = '0;
  logic [6:0] seed7 = '0;

  logic       a_valid, a_wrap, a_lock;
  logic [0:0] a_data;
  logic [3:0] a_state, a_period;
  logic       b_valid, b_wrap, b_lock;
  logic [3:0] b_data, b_state, b_period;
  logic       c_valid, c_wrap, c_lock;
  logic [0:0] c_data;
  logic [6:0] c_state, c_period;

  int          checks = 0;
  int          errors = 0;
  logic [3:0]  exp_q[$];
  logic [31:0] model;
  // serial reference 1,1,1,1,0,1,0,1,1,0,0,1,0,0,0 with bit 0 emitted first
  logic [14:0] serial_ref = 15'b000100110101111;

  prbs_lfsr_gen u_a (
    .clk(clk), .res(res), .en(en), .load(load), .seed(seed4), .out_ready(out_ready),
    .out_valid(a_valid), .out_data(a_data), .state(a_state), .wrap(a_wrap),
    .period(a_period), .lockup_err(a_lock));

  prbs_lfsr_gen #(.OUT_W(4)) u_b (
    .clk(clk), .res(res), .en(en), .load(load), .seed(seed4), .out_ready(out_ready),
    .out_valid(b_valid), .out_data(b_data), .state(b_state), .wrap(b_wrap),
    .period(b_period), .lockup_err(b_lock));

  prbs_lfsr_gen #(.N(7), .TAPS(7'b0000011)) u_c (
    .clk(clk), .res(res), .en(en), .load(load), .seed(seed7), .out_ready(out_ready),
    .out_valid(c_valid), .out_data(c_data), .state(c_state), .wrap(c_wrap),
    .period(c_period), .lockup_err(c_lock));

  always #5 clk = ~clk;

  function automatic logic [31:0] model_step(input logic [31:0] d, input logic [31:0] taps,
                                             input int n);
    logic [31:0] r;
    logic        fb;
    fb = ^(d & taps);
    r = d >> 1;
    r[n-1] = fb;
    return r;
  endfunction

  task automatic reset_dut();
    @(posedge clk); #1;
    res = 1'b0; en = 1'b0; load = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    res = 1'b1;
    exp_q.delete();
    model = 32'hF;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    res = 1'b0; en = 1'b1; load = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (a_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", a_valid); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (a_state !== 4'hF) begin errors++; $display("[TB] FAIL reset_state got %h want f", a_state); end
    checks++;
    if (a_period !== 4'h0) begin errors++; $display("[TB] FAIL reset_period got %h want 0", a_period); end
    checks++;
    if (a_wrap !== 1'b0 || a_lock !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_pulses got wrap=%b lock=%b want 0 0", a_wrap, a_lock);
    end
    checks++;
    if (c_state !== 7'h7F) begin errors++; $display("[TB] FAIL reset_state7 got %h want 7f", c_state); end
    @(posedge clk); #1;
    res = 1'b1; en = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_sequence();
    logic [3:0] exp_w;
    reset_dut();
    for (int k = 0; k <= 30; k++) begin
      en = 1'b1; out_ready = 1'b1;
      exp_q.push_back({3'b000, serial_ref[k % 15]});
      @(negedge clk);
      checks++;
      if (a_wrap !== ((k % 15 == 0) && (k > 0))) begin
        errors++; $display("[TB] FAIL seq_wrap k=%0d got %b", k, a_wrap);
      end
      checks++;
      if (a_valid !== 1'b1) begin
        errors++; $display("[TB] FAIL seq_valid k=%0d got %b want 1", k, a_valid);
      end else begin
        exp_w = exp_q.pop_front();
        checks++;
        if (a_data !== exp_w[0]) begin
          errors++; $display("[TB] FAIL seq_data k=%0d got %b want %b", k, a_data, exp_w[0]);
        end
      end
      if (k == 15) begin
        checks++;
        if (a_period !== 4'd15) begin errors++; $display("[TB] FAIL seq_period got %0d want 15", a_period); end
      end
      @(posedge clk); #1;
    end
    en = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [3:0] exp_w;
    int         push_idx;
    reset_dut();
    push_idx = 0;
    for (int k = 0; k < 22; k++) begin
      en = 1'b1;
      out_ready = !(k >= 7 && k < 12);
      if (out_ready) begin
        exp_q.push_back({3'b000, serial_ref[push_idx % 15]});
        push_idx++;
      end
      @(negedge clk);
      checks++;
      if (a_state !== model[3:0]) begin
        errors++; $display("[TB] FAIL bp_state k=%0d got %h want %h", k, a_state, model[3:0]);
      end
      if (out_ready) begin
        exp_w = exp_q.pop_front();
        checks++;
        if (a_data !== exp_w[0]) begin
          errors++; $display("[TB] FAIL bp_data k=%0d got %b want %b", k, a_data, exp_w[0]);
        end
        model = model_step(model, 32'h9, 4);
      end else begin
        checks++;
        if (a_data !== serial_ref[push_idx % 15]) begin
          errors++; $display("[TB] FAIL bp_frozen k=%0d got %b want %b", k, a_data, serial_ref[push_idx % 15]);
        end
      end
      @(posedge clk); #1;
    end
    en = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_midrun_reset();
    reset_dut();
    for (int k = 0; k < 20; k++) begin
      en = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (a_state !== model[3:0]) begin
        errors++; $display("[TB] FAIL mr_state k=%0d got %h want %h", k, a_state, model[3:0]);
      end
      model = model_step(model, 32'h9, 4);
      @(posedge clk); #1;
    end
    res = 1'b0; #2; res = 1'b1;
    @(negedge clk);
    checks++;
    if (a_valid !== 1'b1 || a_state !== model[3:0]) begin
      errors++; $display("[TB] FAIL mr_glitch got valid=%b state=%h want 1 %h", a_valid, a_state, model[3:0]);
    end
    checks++;
    if (a_period !== 4'd15) begin errors++; $display("[TB] FAIL mr_period_pre got %0d want 15", a_period); end
    model = model_step(model, 32'h9, 4);
    @(posedge clk); #1;
    res = 1'b0;
    @(negedge clk);
    checks++;
    if (a_valid !== 1'b0 || a_state !== model[3:0]) begin
      errors++; $display("[TB] FAIL mr_pending got valid=%b state=%h want 0 %h", a_valid, a_state, model[3:0]);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (a_state !== 4'hF || a_period !== 4'h0 || a_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL mr_after got state=%h period=%0d valid=%b want f 0 0", a_state, a_period, a_valid);
    end
    @(posedge clk); #1;
    res = 1'b1; en = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_load();
    logic [3:0] exp_w;
    reset_dut();
    load = 1'b1; seed4 = 4'b0110; en = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (a_valid !== 1'b0) begin errors++; $display("[TB] FAIL load_valid got %b want 0", a_valid); end
    @(posedge clk); #1;
    load = 1'b0;
    for (int k = 0; k <= 15; k++) begin
      en = 1'b1; out_ready = 1'b1;
      exp_q.push_back({3'b000, serial_ref[(6 + k) % 15]});
      @(negedge clk);
      if (k == 0) begin
        checks++;
        if (a_state !== 4'b0110 || a_data !== 1'b0) begin
          errors++; $display("[TB] FAIL load_state got %b data=%b want 0110 0", a_state, a_data);
        end
      end
      checks++;
      if (a_wrap !== (k == 15)) begin errors++; $display("[TB] FAIL load_wrap k=%0d got %b", k, a_wrap); end
      exp_w = exp_q.pop_front();
      checks++;
      if (a_data !== exp_w[0]) begin
        errors++; $display("[TB] FAIL load_data k=%0d got %b want %b", k, a_data, exp_w[0]);
      end
      if (k == 15) begin
        checks++;
        if (a_period !== 4'd15) begin errors++; $display("[TB] FAIL load_period got %0d want 15", a_period); end
      end
      @(posedge clk); #1;
    end
    load = 1'b1; seed4 = 4'b0000;
    @(posedge clk); #1;
    load = 1'b0; en = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (a_state !== 4'hF || a_lock !== 1'b1) begin
      errors++; $display("[TB] FAIL zero_seed got state=%h lock=%b want f 1", a_state, a_lock);
    end
    checks++;
    if (a_period !== 4'd15) begin errors++; $display("[TB] FAIL zero_seed_period got %0d want 15", a_period); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (a_lock !== 1'b0) begin errors++; $display("[TB] FAIL lock_pulse got %b want 0", a_lock); end
    @(posedge clk); #1;
  endtask

  task automatic test_wide();
    logic [3:0] w;
    logic [3:0] exp_w;
    reset_dut();
    for (int k = 0; k <= 30; k++) begin
      en = 1'b1; out_ready = 1'b1;
      for (int j = 0; j < 4; j++) w[j] = serial_ref[(4 * k + j) % 15];
      exp_q.push_back(w);
      @(negedge clk);
      exp_w = exp_q.pop_front();
      checks++;
      if (b_data !== exp_w) begin
        errors++; $display("[TB] FAIL wide_data k=%0d got %b want %b", k, b_data, exp_w);
      end
      checks++;
      if (b_wrap !== ((k % 15 == 0) && (k > 0))) begin
        errors++; $display("[TB] FAIL wide_wrap k=%0d got %b", k, b_wrap);
      end
      if (k == 1) begin
        checks++;
        if (b_state !== 4'b1010) begin errors++; $display("[TB] FAIL wide_state got %b want 1010", b_state); end
      end
      if (k == 15) begin
        checks++;
        if (b_period !== 4'd15) begin errors++; $display("[TB] FAIL wide_period got %0d want 15", b_period); end
      end
      @(posedge clk); #1;
    end
    en = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_n7();
    logic seen [128];
    bit   found;
    reset_dut();
    model = 32'h7F;
    found = 1'b0;
    for (int i = 0; i < 128; i++) seen[i] = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      en = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      if (c_wrap === 1'b1) begin
        found = 1'b1;
        checks++;
        if (k != 127) begin errors++; $display("[TB] FAIL n7_wrap_at got %0d want 127", k); end
        checks++;
        if (c_period !== 7'd127) begin errors++; $display("[TB] FAIL n7_period got %0d want 127", c_period); end
      end else begin
        checks++;
        if (seen[c_state] !== 1'b0) begin
          errors++; $display("[TB] FAIL n7_repeat k=%0d state %h seen before", k, c_state);
        end
        checks++;
        if (c_state !== model[6:0]) begin
          errors++; $display("[TB] FAIL n7_state k=%0d got %h want %h", k, c_state, model[6:0]);
        end
        seen[c_state] = 1'b1;
      end
      model = model_step(model, 32'h3, 7);
      @(posedge clk); #1;
    end
    if (!found) begin
      checks++; errors++;
      $display("[TB] FAIL n7_timeout got no wrap want wrap within 200 transfers");
    end
    en = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_sequence();
    test_backpressure();
    test_midrun_reset();
    test_load();
    test_wide();
    test_n7();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
